sum_stationary_drain: RTL

//  Downstream drain stage for the sum-stationary NxN matmul array.
//  - Captures the full c[N*N] result when the array flags valid.
//  - Pulses a one-cycle clear back to the array.
//  - Streams the result out one row per beat, N beats, over a valid/ready interface.
//  - Each element is narrowed to OUT_WIDTH on capture.

---
 rtl/sum_stationary_pkg.sv | 32 +++
 rtl/sum_stationary_narrow.sv | 40 ++++
 rtl/sum_stationary_drain.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sum_stationary_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_stationary_pkg
// Purpose  : Shared types and width helpers for the sum-stationary matmul
//            array and its drain stage.
//            - c_width(dw, n): accumulator width produced by an n x n array
//              of dw-bit operands.
//            - row_idx_width(n): width of a row index, never less than 1 bit.
//            - drain_state_e: drain FSM state encoding.
// Config   : none here; the drain's narrowing mode is selected by the
//            DRAIN_SATURATE_EN macro in sum_stationary_narrow.
// Revision : 1.0 - initial release
// ============================================================================
package sum_stationary_pkg;

    // A dot product of n terms, each a dw x dw product, grows by clog2(n) bits.
    function automatic int c_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // $clog2(1) is 0, which would give a zero-width index for a 1x1 array.
    function automatic int row_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

endpackage : sum_stationary_pkg
`default_nettype wire

// File: rtl/sum_stationary_narrow.sv
`default_nettype none
// ============================================================================
// Module   : sum_stationary_narrow
// Purpose  : Combinational narrowing of one unsigned accumulator element
//            from C_DATA_WIDTH to OUT_WIDTH bits.
//            - OUT_WIDTH >= C_DATA_WIDTH : zero-extend.
//            - otherwise, DRAIN_SATURATE_EN defined   : unsigned saturate.
//            - otherwise, DRAIN_SATURATE_EN undefined : keep low OUT_WIDTH bits.
// Ports    : c_elem        in  C_DATA_WIDTH  accumulator element
//            narrowed_elem out OUT_WIDTH     narrowed element
// Config   : DRAIN_SATURATE_EN selects saturation instead of truncation.
// Revision : 1.0 - initial release
// ============================================================================
module sum_stationary_narrow #(
    parameter int C_DATA_WIDTH = 18,
    parameter int OUT_WIDTH    = 16
) (
    input  logic [C_DATA_WIDTH-1:0] c_elem,
    output logic [OUT_WIDTH-1:0]    narrowed_elem
);

    if (OUT_WIDTH >= C_DATA_WIDTH) begin : g_extend
        assign narrowed_elem = OUT_WIDTH'(c_elem);
    end else begin : g_narrow
        // Bits above the output width; any set bit means the value overflows.
        logic [C_DATA_WIDTH-OUT_WIDTH-1:0] high_bits;
        assign high_bits = c_elem[C_DATA_WIDTH-1:OUT_WIDTH];
`ifdef DRAIN_SATURATE_EN
        assign narrowed_elem = (|high_bits) ? {OUT_WIDTH{1'b1}}
                                            : c_elem[OUT_WIDTH-1:0];
`else
        // Truncation discards the high bits by design.
        logic unused_high;
        assign unused_high   = ^high_bits;
        assign narrowed_elem = c_elem[OUT_WIDTH-1:0];
`endif
    end

endmodule : sum_stationary_narrow
`default_nettype wire

// File: rtl/sum_stationary_drain.sv
`default_nettype none
// ============================================================================
// Module   : sum_stationary_drain
// Purpose  : Drain stage for the sum-stationary N x N matmul array.
//            Captures the whole narrowed result matrix when the array flags
//            valid, pulses a one-cycle clear back to the array, then streams
//            the matrix out one row per beat over valid/ready.
// Ports    : clk_i          in   clock
//            reset_i        in   asynchronous active-high reset
//            array_valid_i  in   array result valid (level)
//            array_c_i      in   N*N x C_DATA_WIDTH, row-major (i*N+j)
//            array_clear_o  out  one-cycle clear pulse to the array
//            in_ready_o     out  high while idle (ready for a new matrix)
//            out_valid_o    out  row beat valid
//            out_ready_i    in   consumer accepts the beat
//            out_row_o      out  N x OUT_WIDTH, element j = c(row, j)
//            out_row_idx_o  out  index of the presented row
//            out_last_o     out  high with the final row
// Config   : DRAIN_SATURATE_EN (see sum_stationary_narrow) selects saturating
//            narrowing; default build truncates.
// Revision : 1.0 - initial release
// ============================================================================
module sum_stationary_drain
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = c_width(DATA_WIDTH, N),
    parameter int OUT_WIDTH    = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   array_valid_i,
    input  logic [N*N-1:0][C_DATA_WIDTH-1:0]       array_c_i,
    output logic                                   array_clear_o,
    output logic                                   in_ready_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [N-1:0][OUT_WIDTH-1:0]            out_row_o,
    output logic [row_idx_width(N)-1:0]            out_row_idx_o,
    output logic                                   out_last_o
);

    localparam int               ROW_W    = row_idx_width(N);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    drain_state_e                         state;
    logic [ROW_W-1:0]                     row_idx;
    logic                                 clear;
    logic                                 out_valid;
    logic                                 out_last;
    logic [N-1:0][N-1:0][OUT_WIDTH-1:0]   buffer;
    logic [N*N-1:0][OUT_WIDTH-1:0]        narrowed;

    // ------------------------------------------------------------------------
    // Per-element narrowing, applied before capture so the buffer only ever
    // holds OUT_WIDTH bits per element.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < N * N; k++) begin : g_narrow
        sum_stationary_narrow #(
            .C_DATA_WIDTH (C_DATA_WIDTH),
            .OUT_WIDTH    (OUT_WIDTH)
        ) u_narrow (
            .c_elem        (array_c_i[k]),
            .narrowed_elem (narrowed[k])
        );
    end

    // ------------------------------------------------------------------------
    // Drain FSM. array_valid_i is only looked at in IDLE, so a valid that is
    // still high while the clear propagates through the array is harmless.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            row_idx   <= '0;
            clear     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            buffer    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (array_valid_i) begin
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                buffer[i][j] <= narrowed[i*N+j];
                            end
                        end
                        state     <= STREAM;
                        row_idx   <= '0;
                        clear     <= 1'b1;
                        out_valid <= 1'b1;
                        // A 1x1 array has its only row as the last row.
                        out_last  <= (N == 1);
                    end
                end

                STREAM: begin
                    clear <= 1'b0;
                    // out_valid is always high here, so ready alone transfers.
                    if (out_ready_i) begin
                        if (row_idx == LAST_ROW) begin
                            state     <= IDLE;
                            row_idx   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            row_idx  <= row_idx + 1'b1;
                            out_last <= ((row_idx + 1'b1) == LAST_ROW);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    row_idx   <= '0;
                    clear     <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign array_clear_o = clear;
    assign in_ready_o    = (state == IDLE);
    assign out_valid_o   = out_valid;
    assign out_last_o    = out_last;
    assign out_row_idx_o = row_idx;
    // Row mux straight from the buffer; holds while row_idx holds.
    assign out_row_o     = buffer[row_idx];

endmodule : sum_stationary_drain
`default_nettype wire
